// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if: command, buffer and array signals of the systolic sequencer
interface systolic_seq_ctrl_if #(parameter int AWIDTH = 7);
  logic start;
  logic [AWIDTH-1:0] num_rows;
  logic busy;
  logic done;
  logic in_rd;
  logic [AWIDTH-1:0] in_addr;
  logic [23:0] in_data;
  logic a_en;
  logic [7:0] a_in1, a_in2, a_in3;
  logic [15:0] o_1, o_2, o_3;
  logic out_we;
  logic [AWIDTH-1:0] out_addr;
  logic [47:0] out_data;
  modport master (
    output start, num_rows, in_data, o_1, o_2, o_3,
    input busy, done, in_rd, in_addr, a_en, a_in1, a_in2, a_in3, out_we, out_addr, out_data
  );
  modport slave (
    input start, num_rows, in_data, o_1, o_2, o_3,
    output busy, done, in_rd, in_addr, a_en, a_in1, a_in2, a_in3, out_we, out_addr, out_data
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: streams N skewed vectors through a 3x3 systolic array and writes de-skewed results
module systolic_seq_ctrl #(
  parameter int AWIDTH = 7,
  parameter int LAT = 3
) (
  input logic clk,
  input logic rst,
  systolic_seq_ctrl_if.slave bus
);
  localparam int CW = AWIDTH + 2;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cyc, n;
  logic rd_q, act, wr_nx;
  logic [7:0] b2, b3a, b3b;
  logic [15:0] o1a, o1b, o2a;
  assign act = state == FILL || state == RUN;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.a_en = state == RUN;
  assign bus.in_rd = act && cyc <= n;
  assign bus.in_addr = bus.in_rd ? AWIDTH'(cyc - CW'(1)) : '0;
  // cyc counts cycles since start, so result i lands when cyc = i+LAT+6
  assign wr_nx = act && cyc >= CW'(LAT + 5) && cyc < n + CW'(LAT + 5);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = bus.num_rows == '0 ? DONE : FILL;
      FILL: if (cyc == CW'(2)) state_nx = RUN;
      RUN: if (cyc == n + CW'(LAT + 4)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= '0;
      n <= '0;
      rd_q <= 1'b0;
      b2 <= '0;
      b3a <= '0;
      b3b <= '0;
      o1a <= '0;
      o1b <= '0;
      o2a <= '0;
      bus.a_in1 <= '0;
      bus.a_in2 <= '0;
      bus.a_in3 <= '0;
      bus.out_we <= 1'b0;
      bus.out_addr <= '0;
      bus.out_data <= '0;
    end else begin
      cyc <= state == IDLE ? CW'(1) : cyc + CW'(1);
      if (state == IDLE && bus.start) n <= CW'(bus.num_rows);
      rd_q <= bus.in_rd;
      bus.a_in1 <= rd_q ? bus.in_data[7:0] : '0;
      b2 <= rd_q ? bus.in_data[15:8] : '0;
      bus.a_in2 <= b2;
      b3a <= rd_q ? bus.in_data[23:16] : '0;
      b3b <= b3a;
      bus.a_in3 <= b3b;
      o1a <= bus.o_1;
      o1b <= o1a;
      o2a <= bus.o_2;
      bus.out_we <= wr_nx;
      if (wr_nx) begin
        bus.out_addr <= AWIDTH'(cyc - CW'(LAT + 5));
        bus.out_data <= {bus.o_3, o2a, o1b};
      end
    end
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: randomized cycle-window checks of the systolic sequencer against a spec-level model
module tb_systolic_seq_ctrl;
  localparam int AW = 7;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [23:0] mem [0:127];
  logic [7:0] w1, w2, w3;
  logic [23:0] h1 = '0, h2 = '0, h3 = '0;
  always #5 clk = ~clk;
  systolic_seq_ctrl_if #(.AWIDTH(AW)) bus ();
  systolic_seq_ctrl #(.AWIDTH(AW), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  // input buffer with one-cycle read latency, and an array stub: column j = row j input * weight j, LAT cycles later
  always_ff @(posedge clk) begin
    if (bus.in_rd) bus.in_data <= mem[bus.in_addr];
    h1 <= {h1[15:0], bus.a_in1};
    h2 <= {h2[15:0], bus.a_in2};
    h3 <= {h3[15:0], bus.a_in3};
  end
  assign bus.o_1 = 16'(h1[23:16]) * 16'(w1);
  assign bus.o_2 = 16'(h2[23:16]) * 16'(w2);
  assign bus.o_3 = 16'(h3[23:16]) * 16'(w3);
  function automatic logic [47:0] word(int i);
    return {16'(mem[i][23:16]) * 16'(w3), 16'(mem[i][15:8]) * 16'(w2), 16'(mem[i][7:0]) * 16'(w1)};
  endfunction
  task automatic fill_rand(int n);
    for (int i = 0; i < n; i++) mem[i] = 24'($urandom);
    w1 = 8'($urandom_range(1, 255));
    w2 = 8'($urandom_range(1, 255));
    w3 = 8'($urandom_range(1, 255));
  endtask
  // n rows; sp: cycle of a spurious start; rk: cycle of a reset pulse; tail: idle cycles checked after done
  task automatic run(int n, int sp, int rk, int tail);
    int last, stop, s;
    logic [4:0] ectl, octl;
    logic [23:0] ea, oa;
    logic [AW-1:0] eaddr;
    last = n == 0 ? 1 : n + LAT + 5;
    stop = rk != 0 ? rk + 1 : last + tail;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_rows = AW'(n);
    for (int k = 1; k <= stop; k++) begin
      @(negedge clk);
      bus.start = k == sp;
      bus.num_rows = AW'($urandom);
      rst = k == rk;
      s = k - 3;
      if (rk != 0 && k > rk) begin
        ectl = '0;
        ea = '0;
        eaddr = '0;
      end else begin
        ectl = {k <= last, k == last, n > 0 && k >= 3 && k <= n + LAT + 4, k <= n,
                n > 0 && k >= LAT + 6 && k <= n + LAT + 5};
        ea[7:0] = s >= 0 && s < n ? mem[s][7:0] : 8'h0;
        ea[15:8] = s >= 1 && s <= n ? mem[s - 1][15:8] : 8'h0;
        ea[23:16] = s >= 2 && s <= n + 1 ? mem[s - 2][23:16] : 8'h0;
        eaddr = k <= n ? AW'(k - 1) : '0;
      end
      octl = {bus.busy, bus.done, bus.a_en, bus.in_rd, bus.out_we};
      oa = {bus.a_in3, bus.a_in2, bus.a_in1};
      checks++;
      if (octl !== ectl) begin
        errors++;
        $display("FAIL ctl n=%0d k=%0d {busy,done,a_en,in_rd,out_we} got %b want %b", n, k, octl, ectl);
      end
      checks++;
      if (oa !== ea) begin
        errors++;
        $display("FAIL skew n=%0d k=%0d a_in3..1 got %h want %h", n, k, oa, ea);
      end
      checks++;
      if (bus.in_addr !== eaddr) begin
        errors++;
        $display("FAIL in_addr n=%0d k=%0d got %0d want %0d", n, k, bus.in_addr, eaddr);
      end
      if (ectl[0]) begin
        checks++;
        if (bus.out_addr !== AW'(k - LAT - 6) || bus.out_data !== word(k - LAT - 6)) begin
          errors++;
          $display("FAIL write n=%0d k=%0d got %0d:%h want %0d:%h", n, k, bus.out_addr, bus.out_data,
                   k - LAT - 6, word(k - LAT - 6));
        end
      end
    end
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.num_rows = AW'(5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) begin
        rst = 1'b0;
        bus.start = 1'b0;
      end
      checks++;
      if ({bus.busy, bus.done, bus.a_en, bus.in_rd, bus.out_we} !== 5'b0 ||
          {bus.a_in3, bus.a_in2, bus.a_in1} !== 24'h0 || bus.in_addr !== '0 ||
          bus.out_addr !== '0 || bus.out_data !== 48'h0) begin
        errors++;
        $display("FAIL reset k=%0d busy=%b done=%b a_en=%b in_rd=%b out_we=%b out_data=%h", k, bus.busy,
                 bus.done, bus.a_en, bus.in_rd, bus.out_we, bus.out_data);
      end
    end
  endtask
  task automatic test_single();
    for (int i = 0; i < 4; i++) mem[i] = {8'(i + 3), 8'(i + 2), 8'(i + 1)};
    {w1, w2, w3} = {8'd1, 8'd1, 8'd1};
    run(4, 0, 0, 2);
  endtask
  task automatic test_skew();
    mem[0] = 24'h030201;
    fill_rand(0);
    run(1, 0, 0, 2);
  endtask
  task automatic test_zero();
    run(0, 0, 0, 3);
  endtask
  task automatic test_ignore_start();
    fill_rand(4);
    run(4, 6, 0, 2);
  endtask
  task automatic test_rst_mid();
    fill_rand(4);
    run(4, 0, 7, 0);
    fill_rand(4);
    run(4, 0, 0, 1);
  endtask
  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int n = $urandom_range(1, 20);
      fill_rand(n);
      run(n, 0, 0, 1);
    end
  endtask
  task automatic test_max();
    fill_rand(127);
    run(127, 0, 0, 2);
  endtask
  task automatic test_back_to_back();
    fill_rand(3);
    run(3, 0, 0, 0);
    fill_rand(5);
    run(5, 0, 0, 0);
    run(0, 0, 0, 0);
    fill_rand(2);
    run(2, 0, 0, 2);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.num_rows = '0;
    w1 = 8'd1;
    w2 = 8'd1;
    w3 = 8'd1;
    test_reset();
    test_single();
    test_skew();
    test_zero();
    test_ignore_start();
    test_rst_mid();
    test_random();
    test_max();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencer for the 3x3 weight-stationary systolic array behind the NPU Wishbone slave. On a start command it streams N 24-bit input vectors from the input buffer into the array with the diagonal row skew. It holds the array enable for exactly the required cycles and de-skews the three column outputs into one 48-bit result word per vector. It then writes the results to the output buffer and signals completion.

## Interface
- AWIDTH, 7: address width of the input and output buffers; maximum N = 2^AWIDTH - 1.
- LAT, 3: cycles from a value entering `a_in1` (stream cycle s) until its column-1 result appears on `o_1`. Columns 2 and 3 follow at +1 and +2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle command pulse; ignored unless the block is idle.
- num_rows  in  AWIDTH  vector count N, sampled with `start`.
- busy  out  1  high from the cycle after an accepted `start` through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- in_rd  out  1  input-buffer read strobe.
- in_addr  out  AWIDTH  input-buffer read address.
- in_data  in  24  read data, valid the cycle after `in_rd`. Byte 0 is row 1, byte 1 is row 2, byte 2 is row 3.
- a_en  out  1  array enable.
- a_in1, a_in2, a_in3  out  8 each  array left inputs for rows 1, 2 and 3.
- o_1, o_2, o_3  in  16 each  array bottom outputs for columns 1, 2 and 3.
- out_we  out  1  output-buffer write strobe.
- out_addr  out  AWIDTH  output-buffer write address.
- out_data  out  48  packed as {col3, col2, col1}; col1 occupies [15:0].

## Operation
- States and transitions:
  - IDLE → FILL on `start`, when `start` is seen in IDLE.
  - FILL lasts 2 cycles with `a_en`=0, then goes to RUN.
  - RUN lasts N+LAT+2 cycles with `a_en`=1, then goes to DONE.
  - DONE lasts 1 cycle, then returns to IDLE.
- `start` with `num_rows`=0: go directly to DONE. `done` pulses the next cycle. No reads, no `a_en`, no writes.
- Input reads:
  - Vector i is read at cycle i+1 after `start` (cycle 0), for i = 0..N-1.
  - `in_addr` = i; `in_rd` is high only on these N cycles.
- Skew, with stream cycle s = cycle − 3:
  - `a_in1` = v[s][7:0] when 0≤s<N, else 0.
  - `a_in2` = v[s−1][15:8] when 1≤s≤N, else 0.
  - `a_in3` = v[s−2][23:16] when 2≤s≤N+1, else 0.
  - All three are registered outputs.
- De-skew: `o_3` at stream cycle i+LAT+2 is combined with `o_2` delayed 1 cycle and `o_1` delayed 2 cycles.
- Result write: registered, with `out_we`=1 and `out_addr`=i at stream cycle i+LAT+3. The last write coincides with DONE.
- Outputs are stored raw as 16-bit values. The block performs no saturation or truncation.
- `start` while `busy` is ignored; `num_rows` is not re-sampled.

## Timing
- Reset values: `busy`=0, `done`=0, `in_rd`=0, `in_addr`=0, `a_en`=0, `a_in1..3`=0, `out_we`=0, `out_addr`=0, `out_data`=0. State is IDLE.
- `rst` mid-operation: all outputs return to reset values on the next edge. No further reads or writes occur. Any partial results already written remain in the buffer.
- `rst` and `start` in the same cycle: reset wins and `start` is dropped.
- Total latency from `start` (cycle 0) for N≥1:
  - `a_en` high on cycles 3 .. N+LAT+4.
  - `done` and the last `out_we` on cycle N+LAT+5.
  - `busy` high on cycles 1 .. N+LAT+5.
- Back-to-back: a new `start` is accepted on the first IDLE cycle after DONE, which is cycle N+LAT+6.
- N = 2^AWIDTH−1: address counters must not wrap. The last address is 2^AWIDTH−2.

## Test plan
- Reset: hold `rst` for 2 cycles with `start`=1 → all outputs 0, no `in_rd`.
- Single run, N=4, LAT=3, identity weights, v[i]={i+3, i+2, i+1}:
  - `a_en` high on cycles 3..11.
  - `out_we` on cycles 9..12 with addresses 0..3.
  - `out_data`[i] = {i+3, i+2, i+1}, each as a 16-bit field.
  - `done` pulses on cycle 12; `busy` is low on cycle 13.
- Skew check, N=1, v0=0x030201:
  - `a_in1`=1 on cycle 3.
  - `a_in2`=2 on cycle 4.
  - `a_in3`=3 on cycle 5.
  - All other cycles: `a_in*`=0.
- Zero rows: `start` with `num_rows`=0 → `done` on cycle 1; `a_en`, `in_rd` and `out_we` never assert.
- `start` pulsed during RUN with N=4 → ignored, and the run completes exactly as in the single-run scenario.
- `rst` asserted on cycle 7 of an N=4 run:
  - On cycle 8: `a_en`=0, `busy`=0, no `out_we`.
  - A fresh `start` is then accepted and completes normally.
